// File: rtl/alu32.sv
// rtl/alu32.sv - 32-bit registered ALU with one-cycle latency
// Optional carry/overflow flag logic is enabled by defining ALU32_FLAGS_EN.
module alu32 (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] inp_A,
   input  logic [31:0] inp_B,
   input  logic [2:0]  select,
   output logic [31:0] out,
   output logic        cout,
   output logic        overflow
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_ASR = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_NOR = 3'b111;

   logic        is_sub;
   logic [31:0] b_op;
   logic [31:0] sum;
   logic [31:0] result;

   // ADD and SUB share one adder; SUB is A + ~B + 1.
   assign is_sub = (select == OP_SUB);
   assign b_op   = is_sub ? ~inp_B : inp_B;

`ifdef ALU32_FLAGS_EN
   logic [32:0] sum_ext;
   logic        is_arith;
   logic        cout_next;
   logic        overflow_next;

   assign sum_ext  = {1'b0, inp_A} + {1'b0, b_op} + {32'b0, is_sub};
   assign sum      = sum_ext[31:0];
   assign is_arith = (select == OP_ADD) || is_sub;

   // Overflow: effective operands share a sign and the result sign differs.
   assign cout_next     = is_arith & sum_ext[32];
   assign overflow_next = is_arith & (inp_A[31] == b_op[31]) & (sum[31] != inp_A[31]);

   always_ff @(posedge clk) begin
      if (reset) begin
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         cout     <= cout_next;
         overflow <= overflow_next;
      end
   end
`else
   assign sum      = inp_A + b_op + {31'b0, is_sub};
   assign cout     = 1'b0;
   assign overflow = 1'b0;
`endif

   always_comb begin
      result = 32'h0000_0000;
      case (select)
         OP_AND:  result = inp_A & inp_B;
         OP_OR:   result = inp_A | inp_B;
         OP_ADD:  result = sum;
         OP_XOR:  result = inp_A ^ inp_B;
         OP_SUB:  result = sum;
         OP_ASR:  result = $signed(inp_A) >>> inp_B[4:0];
         OP_SHL:  result = inp_A << inp_B[4:0];
         OP_NOR:  result = ~(inp_A | inp_B);
         default: result = 32'h0000_0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out <= 32'h0000_0000;
      end else begin
         out <= result;
      end
   end

endmodule

// File: tb/tb_alu32.sv
// tb/tb_alu32.sv - scoreboard testbench for alu32
module tb_alu32;

`ifdef ALU32_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   typedef struct {
      logic [31:0] out;
      logic        cout;
      logic        ovf;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] inp_A = '0;
   logic [31:0] inp_B = '0;
   logic [2:0]  select = '0;
   logic [31:0] out;
   logic        cout;
   logic        overflow;

   logic issued = 1'b0;
   bit   done = 1'b0;
   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   alu32 dut (
      .clk(clk),
      .reset(reset),
      .inp_A(inp_A),
      .inp_B(inp_B),
      .select(select),
      .out(out),
      .cout(cout),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic issue(input string name, input logic rst, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] sel,
                        input logic [31:0] e_out, input logic e_c, input logic e_v);
      exp_t e;
      @(negedge clk);
      reset  = rst;
      inp_A  = a;
      inp_B  = b;
      select = sel;
      issued = 1'b1;
      e.out  = e_out;
      e.cout = e_c & FLAGS;
      e.ovf  = e_v & FLAGS;
      e.name = name;
      sb.push_back(e);
   endtask

   // Monitor: every edge that consumed an issued vector yields one result.
   always @(posedge clk) begin
      if (issued && !done) begin
         #1;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output: out=%h with empty scoreboard", out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (out !== e.out || cout !== e.cout || overflow !== e.ovf) begin
               fails++;
               $display("FAIL %s: got out=%h cout=%b ovf=%b, expected out=%h cout=%b ovf=%b",
                        e.name, out, cout, overflow, e.out, e.cout, e.ovf);
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);

      issue("reset",      1'b1, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b0, 1'b0);

      issue("or",         1'b0, 32'hC00000FF, 32'hF1E00000, 3'b001, 32'hF1E000FF, 1'b0, 1'b0);
      issue("xor",        1'b0, 32'hC00000FF, 32'hF1E00000, 3'b011, 32'h31E000FF, 1'b0, 1'b0);
      issue("nor",        1'b0, 32'hC00000FF, 32'hF1E00000, 3'b111, 32'h0E1FFF00, 1'b0, 1'b0);
      issue("and",        1'b0, 32'hC0000000, 32'hC000001F, 3'b000, 32'hC0000000, 1'b0, 1'b0);

      issue("add_carry",  1'b0, 32'hC00000EA, 32'hF1E00000, 3'b010, 32'hB1E000EA, 1'b1, 1'b0);
      issue("add_ovf",    1'b0, 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b1);
      issue("sub_plain",  1'b0, 32'hFF0000FF, 32'h71E0003E, 3'b100, 32'h8D2000C1, 1'b1, 1'b0);
      issue("sub_ovf",    1'b0, 32'h80000000, 32'h00000001, 3'b100, 32'h7FFFFFFF, 1'b1, 1'b1);

      issue("asr3",       1'b0, 32'hC00000FF, 32'h00000003, 3'b101, 32'hF800001F, 1'b0, 1'b0);
      issue("shl3",       1'b0, 32'hC00000FF, 32'h00000003, 3'b110, 32'h000007F8, 1'b0, 1'b0);
      issue("asr0",       1'b0, 32'hC00000FF, 32'hFFFFFFE0, 3'b101, 32'hC00000FF, 1'b0, 1'b0);
      issue("shl0",       1'b0, 32'hC00000FF, 32'hFFFFFFE0, 3'b110, 32'hC00000FF, 1'b0, 1'b0);

      // Back-to-back across all eight codes, A=C00000FF B=F1E00000 (shift amount 0).
      issue("b2b_and",    1'b0, 32'hC00000FF, 32'hF1E00000, 3'b000, 32'hC0000000, 1'b0, 1'b0);
      issue("b2b_or",     1'b0, 32'hC00000FF, 32'hF1E00000, 3'b001, 32'hF1E000FF, 1'b0, 1'b0);
      issue("b2b_add",    1'b0, 32'hC00000FF, 32'hF1E00000, 3'b010, 32'hB1E000FF, 1'b1, 1'b0);
      issue("b2b_xor",    1'b0, 32'hC00000FF, 32'hF1E00000, 3'b011, 32'h31E000FF, 1'b0, 1'b0);
      issue("b2b_sub",    1'b0, 32'hC00000FF, 32'hF1E00000, 3'b100, 32'hCE2000FF, 1'b0, 1'b0);
      issue("b2b_asr",    1'b0, 32'hC00000FF, 32'hF1E00000, 3'b101, 32'hC00000FF, 1'b0, 1'b0);
      issue("b2b_shl",    1'b0, 32'hC00000FF, 32'hF1E00000, 3'b110, 32'hC00000FF, 1'b0, 1'b0);
      issue("b2b_nor",    1'b0, 32'hC00000FF, 32'hF1E00000, 3'b111, 32'h0E1FFF00, 1'b0, 1'b0);

      // Mid-stream reset discards the pending ADD, then operation resumes.
      issue("add_pre",    1'b0, 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b1);
      issue("mid_reset",  1'b1, 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b0, 1'b0);
      issue("post_reset", 1'b0, 32'h00000005, 32'h00000003, 3'b100, 32'h00000002, 1'b1, 1'b0);
      issue("sub_borrow", 1'b0, 32'h00000003, 32'h00000005, 3'b100, 32'hFFFFFFFE, 1'b0, 1'b0);

      @(negedge clk);
      issued = 1'b0;
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      done = 1'b1;

      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu32.md
ALU32 -- requirements
Module: alu32

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 out  output  32  registered ALU result.
REQ-005 cout  output  1  registered carry-out flag.
REQ-006 overflow  output  1  registered signed-overflow flag.
REQ-007 inp_A  input  32  operand A.
REQ-008 inp_B  input  32  operand B; bits [4:0] also serve as shift amount.
REQ-009 select  input  3  operation code.

Function
REQ-010 Operation decode SHALL be: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SUB (A-B), 101 arithmetic right shift of A, 110 logical left shift of A, 111 NOR.
REQ-011 Latency SHALL be one cycle: inputs sampled at rising edge N appear on out/cout/overflow after edge N; outputs hold between edges.
REQ-012 ADD SHALL compute A+B modulo 2^32; cout = bit 32 of the unsigned sum.
REQ-013 SUB SHALL compute A + ~B + 1 modulo 2^32; cout = bit 32 of that sum (1 when A >= B unsigned, i.e. no borrow).
REQ-014 overflow SHALL be 1 for ADD when A and B have equal sign bits and result sign differs; for SUB when A and B signs differ and result sign differs from A; 0 otherwise.
REQ-015 For all non-ADD/SUB operations cout and overflow SHALL be 0.
REQ-016 Shifts SHALL use only inp_B[4:0] (0-31); inp_B[31:5] ignored; shift by 0 returns A unchanged.
REQ-017 Arithmetic right shift SHALL replicate A[31] into vacated bits; left shift SHALL fill zeros and discard bits shifted past bit 31.
REQ-018 Logic ops (AND/OR/XOR/NOR) SHALL be bitwise over all 32 bits.
REQ-019 Outputs SHALL never be X/Z after the first reset edge for known inputs; the design has no handshake and accepts a new operation every cycle.

Reset
REQ-020 While reset is high at a rising edge, out SHALL load 32'h00000000, cout 0, overflow 0.
REQ-021 Reset SHALL take priority over any operation presented in the same cycle; reset asserted mid-stream discards the pending result.
REQ-022 First valid result after reset deasserts SHALL appear one edge after the first non-reset edge.

Configuration
REQ-023 Macro ALU32_FLAGS_EN: when defined, cout and overflow behave per REQ-012..REQ-015.
REQ-024 When ALU32_FLAGS_EN is undefined, cout and overflow SHALL be tied to constant 0 and no flag logic synthesized; out unaffected.

Verification (ALU32_FLAGS_EN defined)
REQ-025 Reset: reset=1 one edge with A=FFFFFFFF,B=1,select=010 -> out=00000000, cout=0, overflow=0.
REQ-026 Logic: A=C00000FF,B=F1E00000: select 001 -> F1E000FF; 011 -> 31E000FF; 111 -> 0E1FFF00; A=C0000000,B=C000001F, 000 -> C0000000; flags 0.
REQ-027 ADD: A=C00000EA,B=F1E00000 -> out=B1E000EA, cout=1, overflow=0; A=7FFFFFFF,B=00000001 -> 80000000, cout=0, overflow=1.
REQ-028 SUB: A=FF0000FF,B=71E0003E -> out=8D2000C1, cout=1, overflow=0; A=80000000,B=00000001 -> 7FFFFFFF, cout=1, overflow=1.
REQ-029 Shifts: A=C00000FF,B=00000003: select 101 -> F800001F; 110 -> 000007F8; B=FFFFFFE0 (amount 0) -> C00000FF both; flags 0.
REQ-030 Back-to-back: change select every cycle across all 8 codes -> each result appears exactly one edge later; reset asserted mid-sequence -> zeros next edge.
